spike_arbiter: RTL and testbench

SPIKE_ARBITER -- requirements
Module: spike_arbiter

---
 rtl/spike_pkg.sv | 14 +
 rtl/spike_prio_enc.sv | 35 +++
 rtl/spike_arbiter.sv | 110 +++++++++++
 tb/tb_spike_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_pkg.sv
// spike_pkg -- shared definitions for the spike arbiter slice.
//   MODE_FIXED / MODE_RR : arbitration policy selectors for spike_arbiter.MODE
//   spike_state_t        : arbiter FSM state (IDLE = nothing offered, OFFER = event on address)
package spike_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } spike_state_t;

endpackage

// File: rtl/spike_prio_enc.sv
// spike_prio_enc -- combinational wrapped first-set finder.
//   vec   : candidate vector, N_CH bits
//   start : index where the search begins (0 gives a plain lowest-index search)
//   found : at least one bit of vec is set
//   index : first set bit at or above start, wrapping through N_CH-1 back to 0
module spike_prio_enc #(
    parameter  int N_CH   = 16,
    localparam int ADDR_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]   vec,
    input  logic [ADDR_W-1:0] start,
    output logic              found,
    output logic [ADDR_W-1:0] index
);

    // One spare bit so start + offset cannot overflow before the wrap.
    logic [ADDR_W:0] pos;

    always_comb begin
        found = 1'b0;
        index = '0;
        pos   = '0;
        for (int i = 0; i < N_CH; i++) begin
            pos = {1'b0, start} + (ADDR_W + 1)'(i);
            if (pos >= (ADDR_W + 1)'(N_CH)) begin
                pos = pos - (ADDR_W + 1)'(N_CH);
            end
            if (!found && vec[pos[ADDR_W-1:0]]) begin
                found = 1'b1;
                index = pos[ADDR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/spike_arbiter.sv
// spike_arbiter -- collects single-cycle spike events from N_CH channels and
// serialises them onto one address-event output.
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   spikes_in  : per-channel event strobes (one event per high cycle)
//   ack_in     : downstream takes the offered event this cycle
//   spike_out  : registered valid, an event is offered on address
//   address    : registered channel index of the offered event
//   acks_out   : registered one-hot acknowledge, one cycle after each handshake
//   ovf_out    : registered pulse, an event merged into an already pending one
//
// Handshake: an event transfers on every rising edge where spike_out and
// ack_in are both high. While spike_out is high and ack_in is low, address
// and spike_out hold unchanged. ack_in is ignored while spike_out is low.
module spike_arbiter
    import spike_pkg::*;
#(
    parameter  int N_CH   = 16,
    parameter  int MODE   = MODE_RR,
    localparam int ADDR_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   spikes_in,
    input  logic              ack_in,
    output logic              spike_out,
    output logic [ADDR_W-1:0] address,
    output logic [N_CH-1:0]   acks_out,
    output logic              ovf_out
);

    spike_state_t      state;
    logic [N_CH-1:0]   pend;
    logic [N_CH-1:0]   clr;
    logic [N_CH-1:0]   cand;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_next;
    logic [ADDR_W-1:0] start;
    logic [ADDR_W-1:0] win;
    logic              found;
    logic              handshake;

    assign handshake = (state == ST_OFFER) && ack_in;
    assign clr       = handshake ? (N_CH'(1) << address) : '0;

    // In IDLE clr is zero, so cand is simply the pending vector; in OFFER
    // after a handshake it excludes the channel just served.
    assign cand      = pend & ~clr;

    assign ptr_next  = (address == ADDR_W'(N_CH - 1)) ? '0 : address + 1'b1;

    // The search after a handshake must already use the advanced pointer,
    // otherwise back-to-back grants would start from the stale position.
    assign start     = (MODE == MODE_RR) ? (handshake ? ptr_next : ptr) : '0;

    spike_prio_enc #(
        .N_CH (N_CH)
    ) u_enc (
        .vec   (cand),
        .start (start),
        .found (found),
        .index (win)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            pend      <= '0;
            ptr       <= '0;
            spike_out <= 1'b0;
            address   <= '0;
            acks_out  <= '0;
            ovf_out   <= 1'b0;
        end else begin
            // A strobe landing on a bit cleared this cycle is a fresh event;
            // only a strobe on a bit that stays pending is lost.
            pend     <= cand | spikes_in;
            acks_out <= clr;
            ovf_out  <= |(spikes_in & cand);

            if (handshake) begin
                ptr <= ptr_next;
            end

            case (state)
                ST_IDLE: begin
                    if (found) begin
                        address   <= win;
                        spike_out <= 1'b1;
                        state     <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (ack_in) begin
                        if (found) begin
                            address <= win;
                        end else begin
                            spike_out <= 1'b0;
                            state     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    spike_out <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_arbiter.sv
// tb_spike_arbiter -- three arbiter instances (16ch round-robin, 16ch fixed,
// 12ch round-robin) fed the same strobes and acknowledge, each checked every
// cycle against an event-level model, plus directed scenarios with literal
// expectations.
module tb_spike_arbiter;
    import spike_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] spk16;
    logic        ack;

    logic        r16_spike, f16_spike, r12_spike;
    logic [3:0]  r16_addr,  f16_addr,  r12_addr;
    logic [15:0] r16_acks,  f16_acks;
    logic [11:0] r12_acks;
    logic        r16_ovf,   f16_ovf,   r12_ovf;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    spike_arbiter #(.N_CH(16), .MODE(MODE_RR)) u_rr16 (
        .clk(clk), .rst(rst), .spikes_in(spk16), .ack_in(ack),
        .spike_out(r16_spike), .address(r16_addr), .acks_out(r16_acks), .ovf_out(r16_ovf));

    spike_arbiter #(.N_CH(16), .MODE(MODE_FIXED)) u_fx16 (
        .clk(clk), .rst(rst), .spikes_in(spk16), .ack_in(ack),
        .spike_out(f16_spike), .address(f16_addr), .acks_out(f16_acks), .ovf_out(f16_ovf));

    spike_arbiter #(.N_CH(12), .MODE(MODE_RR)) u_rr12 (
        .clk(clk), .rst(rst), .spikes_in(spk16[11:0]), .ack_in(ack),
        .spike_out(r12_spike), .address(r12_addr), .acks_out(r12_acks), .ovf_out(r12_ovf));

    // ---------------- checking helper ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- event-level model ----------------
    // Index 0 = rr16, 1 = fx16, 2 = rr12.
    int          m_n[3]  = '{16, 16, 12};
    bit          m_rr[3] = '{1'b1, 1'b0, 1'b1};
    string       m_nm[3] = '{"rr16", "fx16", "rr12"};
    logic [63:0] m_pend[3];
    bit          m_offer[3];
    int          m_addr[3];
    int          m_ptr[3];
    logic [63:0] m_ack[3];
    bit          m_ovf[3];

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_pend[k]  = '0;
            m_offer[k] = 1'b0;
            m_addr[k]  = 0;
            m_ptr[k]   = 0;
            m_ack[k]   = '0;
            m_ovf[k]   = 1'b0;
        end
    endtask

    // One clock edge: serve the offered event if acknowledged, note lost
    // strobes, pick the next event from what is still waiting, then record
    // the new strobes.
    task automatic model_step(input int k, input logic [63:0] spk, input bit a);
        int          n;
        bit          served;
        logic [63:0] waiting;
        logic [63:0] mask;
        int          first;
        int          start;
        n       = m_n[k];
        mask    = (64'd1 << n) - 64'd1;
        served  = m_offer[k] && a;
        waiting = m_pend[k];
        m_ack[k] = '0;
        if (served) begin
            waiting[m_addr[k]] = 1'b0;
            m_ack[k][m_addr[k]] = 1'b1;
            m_ptr[k] = (m_addr[k] + 1) % n;
        end
        m_ovf[k] = |(spk & mask & waiting);
        if (!m_offer[k] || served) begin
            first = -1;
            start = m_rr[k] ? m_ptr[k] : 0;
            for (int s = 0; s < n; s++) begin
                int c;
                c = (start + s) % n;
                if (first < 0 && waiting[c]) first = c;
            end
            m_offer[k] = (first >= 0);
            if (first >= 0) m_addr[k] = first;
        end
        m_pend[k] = waiting | (spk & mask);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < 3; k++) model_step(k, {48'b0, spk16}, ack);
        end
    end

    // ---------------- per-cycle compare ----------------
    logic        d_spike[3];
    logic [3:0]  d_addr[3];
    logic [63:0] d_acks[3];
    logic        d_ovf[3];

    assign d_spike[0] = r16_spike;  assign d_addr[0] = r16_addr;
    assign d_acks[0]  = {48'b0, r16_acks};  assign d_ovf[0] = r16_ovf;
    assign d_spike[1] = f16_spike;  assign d_addr[1] = f16_addr;
    assign d_acks[1]  = {48'b0, f16_acks};  assign d_ovf[1] = f16_ovf;
    assign d_spike[2] = r12_spike;  assign d_addr[2] = r12_addr;
    assign d_acks[2]  = {52'b0, r12_acks};  assign d_ovf[2] = r12_ovf;

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 3; k++) begin
                chk({m_nm[k], " spike_out"}, 64'(d_spike[k]), 64'(m_offer[k]));
                if (m_offer[k]) chk({m_nm[k], " address"}, 64'(d_addr[k]), 64'(m_addr[k]));
                chk({m_nm[k], " acks_out"}, d_acks[k], m_ack[k]);
                chk({m_nm[k], " ovf_out"}, 64'(d_ovf[k]), 64'(m_ovf[k]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic drain();
        spk16 = '0;
        ack   = 1'b1;
        repeat (40) step();
    endtask

    int exp_seq[6] = '{2, 5, 9, 2, 5, 9};

    initial begin
        rst   = 1'b1;
        spk16 = '0;
        ack   = 1'b0;
        repeat (3) step();
        chk("reset spike_out", 64'(r16_spike), 64'd0);
        chk("reset address",   64'(r16_addr),  64'd0);
        chk("reset acks_out",  64'(r16_acks),  64'd0);
        chk("reset ovf_out",   64'(r16_ovf),   64'd0);
        rst = 1'b0;
        started = 1'b1;

        // Round-robin over held channels 2,5,9 with no gap cycles.
        begin
            int waited;
            spk16 = 16'h0224;
            ack   = 1'b1;
            waited = 0;
            while (!r16_spike && waited < 10) begin
                step();
                waited++;
            end
            chk("rr seq start", 64'(r16_spike), 64'd1);
            for (int j = 0; j < 6; j++) begin
                chk($sformatf("rr seq addr %0d", j), 64'(r16_addr), 64'(exp_seq[j]));
                chk($sformatf("rr seq valid %0d", j), 64'(r16_spike), 64'd1);
                step();
            end
        end
        drain();

        // Fixed priority: 8001 strobed once, ack held.
        spk16 = 16'h8001; ack = 1'b1;
        step(); spk16 = '0;
        chk("fx latency t+1", 64'(f16_spike), 64'd0);
        step();
        chk("fx t+2 valid", 64'(f16_spike), 64'd1);
        chk("fx t+2 addr",  64'(f16_addr),  64'd0);
        chk("model t+2 addr", 64'(m_addr[1]), 64'd0);
        step();
        chk("fx t+3 addr", 64'(f16_addr), 64'd15);
        chk("fx t+3 acks", 64'(f16_acks), 64'h0001);
        step();
        chk("fx t+4 acks",  64'(f16_acks),  64'h8000);
        chk("fx t+4 idle",  64'(f16_spike), 64'd0);
        chk("model t+4 idle", 64'(m_offer[1]), 64'd0);
        drain();

        // Offer held stable under back-pressure despite a higher-priority strobe.
        ack = 1'b0; spk16 = 16'h0008;
        step(); spk16 = '0;
        step();
        chk("hold addr3", 64'(f16_addr), 64'd3);
        spk16 = 16'h0001;
        step(); spk16 = '0;
        for (int j = 0; j < 10; j++) begin
            chk("hold stable addr", 64'(f16_addr), 64'd3);
            chk("hold stable valid", 64'(f16_spike), 64'd1);
            step();
        end
        ack = 1'b1;
        step();
        chk("after hold addr", 64'(f16_addr), 64'd0);
        chk("after hold acks", 64'(f16_acks), 64'h0008);
        drain();

        // Merged strobe on a pending channel.
        ack = 1'b0; spk16 = 16'h0010;
        step(); spk16 = '0;
        step();
        chk("ovf offer addr", 64'(f16_addr), 64'd4);
        spk16 = 16'h0010;
        step(); spk16 = '0;
        chk("ovf pulse", 64'(f16_ovf), 64'd1);
        step();
        chk("ovf one cycle", 64'(f16_ovf), 64'd0);
        ack = 1'b1;
        step();
        chk("ovf acks", 64'(f16_acks), 64'h0010);
        chk("ovf single event", 64'(f16_spike), 64'd0);
        step();
        chk("ovf stays idle", 64'(f16_spike), 64'd0);
        drain();

        // 12 channels: grant of 11 wraps the pointer to 0.
        ack = 1'b0; spk16 = 16'h0800;
        step(); spk16 = '0;
        step();
        chk("wrap offer 11", 64'(r12_addr), 64'd11);
        spk16 = 16'h0001;
        step();
        spk16 = 16'h0800; ack = 1'b1;
        step(); spk16 = '0;
        chk("wrap next addr", 64'(r12_addr), 64'd0);
        chk("wrap acks", 64'(r12_acks), 64'h800);
        chk("wrap refill no ovf", 64'(r12_ovf), 64'd0);
        step();
        chk("wrap then 11", 64'(r12_addr), 64'd11);
        drain();

        // Reset in the middle of an offer with three events pending.
        ack = 1'b0; spk16 = 16'h000E;
        step(); spk16 = '0;
        step();
        chk("pre reset offer", 64'(f16_spike), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async rst spike", 64'({r16_spike, f16_spike, r12_spike}), 64'd0);
        chk("async rst addr",  64'({r16_addr, f16_addr, r12_addr}), 64'd0);
        chk("async rst acks",  64'({r16_acks, f16_acks, r12_acks}), 64'd0);
        chk("async rst ovf",   64'({r16_ovf, f16_ovf, r12_ovf}), 64'd0);
        step();
        rst = 1'b0; ack = 1'b1;
        for (int j = 0; j < 6; j++) begin
            step();
            chk("post reset quiet", 64'({r16_spike, f16_spike, r12_spike}), 64'd0);
            chk("post reset no acks", 64'({r16_acks, f16_acks, r12_acks}), 64'd0);
        end

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < 16; b++) spk16[b] = ($urandom_range(7) == 0);
            ack = ($urandom_range(3) != 0);
            step();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
